// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder and its storage arrays.
package mem_responder_pkg;

  localparam int ADDR_W          = 4;
  localparam int IDATA_W         = 32;
  localparam int DDATA_W         = 8;
  localparam int CNT_W           = 4;
  localparam int DEFAULT_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  typedef enum logic {
    SEL_INSTR = 1'b0,
    SEL_DATA  = 1'b1
  } port_sel_t;

  // Wait-counter reload value; legal latencies 0..15 fit the counter exactly.
  function automatic logic [CNT_W-1:0] latency_to_cnt(input int lat);
    return lat[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port storage array with a registered, resettable read port.
// Contents start at zero and are never cleared by reset; only the read register is.
module mem_array #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
  logic [WIDTH-1:0] r_rdata;

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Registered read, held until the next read enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: arbitrates instruction-fetch and data ports onto a 16x32
// instruction store and a 16x8 data store with a programmable wait latency.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int IDEPTH  = 16,
  parameter int DDEPTH  = 16,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_req,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic               i_ack,
  output logic [IDATA_W-1:0] i_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [DDATA_W-1:0] d_wdata,
  output logic               d_ack,
  output logic [DDATA_W-1:0] d_rdata,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [IDATA_W-1:0] prog_data,
  output logic               busy
);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  port_sel_t          r_sel, w_sel_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic               r_we, w_we_nxt;
  logic [DDATA_W-1:0] r_wdata, w_wdata_nxt;
  logic               w_access;

  logic               r_i_ack, r_d_ack, r_busy;

  logic               w_prog_wr;
  logic               w_istore_we, w_istore_re;
  logic [ADDR_W-1:0]  w_istore_addr;
  logic               w_dstore_we, w_dstore_re;

  // Next-state, wait counter and arbitration (prog_we > d_req > i_req in IDLE).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_addr_nxt  = r_addr;
    w_we_nxt    = r_we;
    w_wdata_nxt = r_wdata;
    w_access    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (prog_we) begin
          w_state_nxt = ST_IDLE;
        end else if (d_req) begin
          w_sel_nxt   = SEL_DATA;
          w_addr_nxt  = d_addr;
          w_we_nxt    = d_we;
          w_wdata_nxt = d_wdata;
          w_cnt_nxt   = latency_to_cnt(LATENCY);
          w_state_nxt = ST_WAIT;
        end else if (i_req) begin
          w_sel_nxt   = SEL_INSTR;
          w_addr_nxt  = i_addr;
          w_we_nxt    = 1'b0;
          w_wdata_nxt = '0;
          w_cnt_nxt   = latency_to_cnt(LATENCY);
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt != {CNT_W{1'b0}}) begin
          w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          w_access    = 1'b1;
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        // Requests are not sampled here so the requester can drop req.
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Store port steering: program loads only in IDLE, accesses at end of WAIT.
  assign w_prog_wr     = (r_state == ST_IDLE) && prog_we;
  assign w_istore_we   = w_prog_wr;
  assign w_istore_re   = w_access && (r_sel == SEL_INSTR);
  assign w_istore_addr = w_prog_wr ? prog_addr : r_addr;
  assign w_dstore_we   = w_access && (r_sel == SEL_DATA) && r_we;
  assign w_dstore_re   = w_access && (r_sel == SEL_DATA) && !r_we;

  // Control state and latched request; a reset drops any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sel   <= SEL_INSTR;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      r_addr  <= w_addr_nxt;
      r_we    <= w_we_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  // Registered acks and busy, aligned with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_i_ack <= (w_state_nxt == ST_ACK) && (r_sel == SEL_INSTR);
      r_d_ack <= (w_state_nxt == ST_ACK) && (r_sel == SEL_DATA);
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  mem_array #(
    .DEPTH (IDEPTH),
    .WIDTH (IDATA_W),
    .AW    (ADDR_W)
  ) u_istore (
    .clk     (clk),
    .rst     (reset),
    .i_we    (w_istore_we),
    .i_re    (w_istore_re),
    .i_addr  (w_istore_addr),
    .i_wdata (prog_data),
    .o_rdata (i_rdata)
  );

  mem_array #(
    .DEPTH (DDEPTH),
    .WIDTH (DDATA_W),
    .AW    (ADDR_W)
  ) u_dstore (
    .clk     (clk),
    .rst     (reset),
    .i_we    (w_dstore_we),
    .i_re    (w_dstore_re),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (d_rdata)
  );

  assign i_ack = r_i_ack;
  assign d_ack = r_d_ack;
  assign busy  = r_busy;

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder: LATENCY=2 main instance plus a
// LATENCY=0 instance for the streaming-fetch case.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        i_req = 1'b0;
  logic [3:0]  i_addr = 4'd0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_addr = 4'd0;
  logic [7:0]  d_wdata = 8'd0;
  logic        d_ack;
  logic [7:0]  d_rdata;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = 4'd0;
  logic [31:0] prog_data = 32'd0;
  logic        busy;

  logic        z_i_req = 1'b0;
  logic [3:0]  z_i_addr = 4'd0;
  logic        z_i_ack;
  logic [31:0] z_i_rdata;
  logic        z_d_ack;
  logic [7:0]  z_d_rdata;
  logic        z_prog_we = 1'b0;
  logic [3:0]  z_prog_addr = 4'd0;
  logic [31:0] z_prog_data = 32'd0;
  logic        z_busy;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_responder #(.IDEPTH(16), .DDEPTH(16), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .busy(busy)
  );

  mem_responder #(.IDEPTH(16), .DDEPTH(16), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .i_req(z_i_req), .i_addr(z_i_addr), .i_ack(z_i_ack), .i_rdata(z_i_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(4'd0), .d_wdata(8'd0),
    .d_ack(z_d_ack), .d_rdata(z_d_rdata),
    .prog_we(z_prog_we), .prog_addr(z_prog_addr), .prog_data(z_prog_data),
    .busy(z_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_load(input logic [3:0] addr, input logic [31:0] data);
    prog_we = 1'b1; prog_addr = addr; prog_data = data;
    tick();
    prog_we = 1'b0;
  endtask

  // Fetch; cyc = edges from first edge to ack (-1 on timeout). Leaves ACK state.
  task automatic i_access(input logic [3:0] addr, output int cyc, output logic [31:0] rd);
    bit got = 1'b0;
    i_req = 1'b1; i_addr = addr; cyc = 0;
    while (!got && cyc < 30) begin
      tick(); cyc++;
      if (i_ack) got = 1'b1;
    end
    i_req = 1'b0; rd = i_rdata;
    if (!got) cyc = -1;
    tick();
  endtask

  task automatic d_access(input logic we, input logic [3:0] addr, input logic [7:0] wd,
                          output int cyc, output logic [7:0] rd);
    bit got = 1'b0;
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd; cyc = 0;
    while (!got && cyc < 30) begin
      tick(); cyc++;
      if (d_ack) got = 1'b1;
    end
    d_req = 1'b0; d_we = 1'b0; rd = d_rdata;
    if (!got) cyc = -1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    tests_run++;
    if ({i_ack, d_ack, busy} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_ctrl: got %b expected 000", {i_ack, d_ack, busy});
    end
    tests_run++;
    if (i_rdata !== 32'h0000_0000 || d_rdata !== 8'h00) begin
      tests_failed++; $display("FAIL reset_rdata: got %h/%h expected 0/0", i_rdata, d_rdata);
    end
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    int cyc; logic [31:0] rd;
    prog_load(4'd3, 32'h0083_2020);
    i_req = 1'b1; i_addr = 4'd3; cyc = 0;
    while (cyc < 3) begin
      tick(); cyc++;
      tests_run++;
      if (i_ack !== 1'b0) begin
        tests_failed++; $display("FAIL fetch_early_ack: edge %0d got %b expected 0", cyc, i_ack);
      end
    end
    tick();
    tests_run++;
    if (i_ack !== 1'b1 || i_rdata !== 32'h0083_2020) begin
      tests_failed++; $display("FAIL fetch_ack: got ack %b data %h expected 1 00832020", i_ack, i_rdata);
    end
    tests_run++;
    if (d_ack !== 1'b0) begin
      tests_failed++; $display("FAIL fetch_no_dack: got %b expected 0", d_ack);
    end
    i_req = 1'b0;
    tick();
    tests_run++;
    if (i_ack !== 1'b0 || busy !== 1'b0 || i_rdata !== 32'h0083_2020) begin
      tests_failed++; $display("FAIL fetch_after: got ack %b busy %b data %h expected 0 0 00832020", i_ack, busy, i_rdata);
    end
    i_access(4'd3, cyc, rd);
    tests_run++;
    if (cyc !== 4) begin
      tests_failed++; $display("FAIL fetch_latency: got %0d expected 4", cyc);
    end
  endtask

  task automatic test_write_read();
    int cyc; logic [7:0] rd;
    d_access(1'b1, 4'd5, 8'hA7, cyc, rd);
    tests_run++;
    if (cyc !== 4 || rd !== 8'h00) begin
      tests_failed++; $display("FAIL write_ack: got cyc %0d rdata %h expected 4 00", cyc, rd);
    end
    d_access(1'b0, 4'd5, 8'h00, cyc, rd);
    tests_run++;
    if (cyc !== 4 || rd !== 8'hA7) begin
      tests_failed++; $display("FAIL read_back: got cyc %0d rdata %h expected 4 a7", cyc, rd);
    end
  endtask

  task automatic test_arbitration();
    int cyc, n, d_edge, i_edge; logic [7:0] rd; logic [7:0] d_val; logic [31:0] i_val;
    d_access(1'b1, 4'd2, 8'h3C, cyc, rd);
    prog_load(4'd0, 32'h1234_5678);
    d_edge = -1; i_edge = -1; d_val = 8'h00; i_val = 32'h0; n = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 4'd2; i_req = 1'b1; i_addr = 4'd0;
    while (i_edge < 0 && n < 30) begin
      tick(); n++;
      if (d_ack && d_edge < 0) begin d_edge = n; d_val = d_rdata; d_req = 1'b0; end
      if (i_ack && i_edge < 0) begin i_edge = n; i_val = i_rdata; i_req = 1'b0; end
    end
    d_req = 1'b0; i_req = 1'b0;
    tick();
    tests_run++;
    if (d_edge !== 4 || d_val !== 8'h3C) begin
      tests_failed++; $display("FAIL arb_data_first: got edge %0d data %h expected 4 3c", d_edge, d_val);
    end
    tests_run++;
    if (i_edge !== 9 || i_val !== 32'h1234_5678) begin
      tests_failed++; $display("FAIL arb_instr_second: got edge %0d data %h expected 9 12345678", i_edge, i_val);
    end
  endtask

  task automatic test_prog_collision();
    int cyc; bit got; logic [31:0] rd;
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = 32'hDEAD_BEEF;
    d_req = 1'b1; d_we = 1'b0; d_addr = 4'd5;
    tick(); cyc = 1; got = 1'b0;
    prog_we = 1'b0;
    while (!got && cyc < 30) begin
      tick(); cyc++;
      if (d_ack) got = 1'b1;
    end
    d_req = 1'b0;
    tests_run++;
    if (!got || cyc !== 5 || d_rdata !== 8'hA7) begin
      tests_failed++; $display("FAIL prog_vs_dreq: got cyc %0d data %h expected 5 a7", cyc, d_rdata);
    end
    tick();
    i_access(4'd1, cyc, rd);
    tests_run++;
    if (rd !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL prog_commit: got %h expected deadbeef", rd);
    end
    // prog_we pulsed while a fetch of the same word is in flight
    i_req = 1'b1; i_addr = 4'd1;
    tick();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL busy_in_wait: got %b expected 1", busy);
    end
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = 32'h0BAD_F00D;
    tick();
    prog_we = 1'b0;
    cyc = 2; got = 1'b0;
    while (!got && cyc < 30) begin
      tick(); cyc++;
      if (i_ack) got = 1'b1;
    end
    i_req = 1'b0;
    tick();
    tests_run++;
    if (!got || cyc !== 4 || i_rdata !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL busy_fetch: got cyc %0d data %h expected 4 deadbeef", cyc, i_rdata);
    end
    i_access(4'd1, cyc, rd);
    tests_run++;
    if (rd !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL prog_ignored_busy: got %h expected deadbeef", rd);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, acks; logic [7:0] rd; logic [31:0] ird;
    d_access(1'b1, 4'd9, 8'h00, cyc, rd);
    d_access(1'b0, 4'd5, 8'h00, cyc, rd);
    d_req = 1'b1; d_we = 1'b1; d_addr = 4'd9; d_wdata = 8'h55;
    tick(); tick();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL mid_busy: got %b expected 1", busy);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || d_ack !== 1'b0 || i_rdata !== 32'h0 || d_rdata !== 8'h00) begin
      tests_failed++; $display("FAIL mid_reset_outs: got busy %b dack %b %h %h expected 0 0 0 0", busy, d_ack, i_rdata, d_rdata);
    end
    d_req = 1'b0; d_we = 1'b0;
    tick(); tick();
    reset = 1'b0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (d_ack || i_ack) acks++;
    end
    tests_run++;
    if (acks !== 0) begin
      tests_failed++; $display("FAIL mid_no_ack: got %0d acks expected 0", acks);
    end
    d_access(1'b0, 4'd9, 8'h00, cyc, rd);
    tests_run++;
    if (cyc !== 4 || rd !== 8'h00) begin
      tests_failed++; $display("FAIL mid_no_commit: got cyc %0d data %h expected 4 00", cyc, rd);
    end
    i_access(4'd3, cyc, ird);
    tests_run++;
    if (ird !== 32'h0083_2020) begin
      tests_failed++; $display("FAIL istore_survives: got %h expected 00832020", ird);
    end
  endtask

  task automatic test_back_to_back();
    int acks, first, prev, bad_space, bad_data, consec, dacks;
    z_prog_we = 1'b1; z_prog_addr = 4'd0; z_prog_data = 32'hCAFE_0001;
    tick();
    z_prog_we = 1'b0;
    z_i_req = 1'b1; z_i_addr = 4'd0;
    acks = 0; first = -1; prev = -100; bad_space = 0; bad_data = 0; consec = 0; dacks = 0;
    for (int n = 1; n <= 15; n++) begin
      tick();
      if (z_d_ack) dacks++;
      if (z_i_ack) begin
        acks++;
        if (first < 0) first = n;
        if (prev > 0 && (n - prev) != 3) bad_space++;
        if ((n - prev) == 1) consec++;
        if (z_i_rdata !== 32'hCAFE_0001) bad_data++;
        prev = n;
      end
    end
    z_i_req = 1'b0;
    tick(); tick();
    tests_run++;
    if (first !== 2 || acks !== 5) begin
      tests_failed++; $display("FAIL lat0_count: got first %0d acks %0d expected 2 5", first, acks);
    end
    tests_run++;
    if (bad_space !== 0 || consec !== 0) begin
      tests_failed++; $display("FAIL lat0_spacing: got bad %0d consec %0d expected 0 0", bad_space, consec);
    end
    tests_run++;
    if (bad_data !== 0 || dacks !== 0) begin
      tests_failed++; $display("FAIL lat0_data: got bad %0d dacks %0d expected 0 0", bad_data, dacks);
    end
    tests_run++;
    if (z_busy !== 1'b0 || z_d_rdata !== 8'h00) begin
      tests_failed++; $display("FAIL lat0_idle: got busy %b drdata %h expected 0 00", z_busy, z_d_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write_read();
    test_arbitration();
    test_prog_collision();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d run %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory responder serving the multi-cycle processor's instruction-fetch and data-load ports through a req/ack handshake with configurable access latency. It holds a 16x32 instruction store and a 16x8 data store, arbitrates between the two requester ports, and exposes a program-load write port for filling the instruction store while idle. It sits between the processor core and the storage arrays.

## Interface
- IDEPTH, 16: instruction store depth, in words.
- DDEPTH, 16: data store depth, in bytes.
- LATENCY, 2: extra wait cycles before each ack; legal range 0..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; returns all control state to idle.
- i_req  in  1  instruction-fetch request; held with i_addr stable until i_ack.
- i_addr  in  4  instruction word address.
- i_ack  out  1  one-cycle pulse; i_rdata is valid in the same cycle.
- i_rdata  out  32  fetched instruction word; held until the next i_ack.
- d_req  in  1  data request; held with d_we, d_addr and d_wdata stable until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  4  data byte address.
- d_wdata  in  8  write data.
- d_ack  out  1  one-cycle pulse.
- d_rdata  out  8  read data; held until the next read ack. Unchanged by writes.
- prog_we  in  1  instruction-store write strobe.
- prog_addr  in  4  program-load address.
- prog_data  in  32  program-load word.
- busy  out  1  high while not IDLE.

## Operation
- The FSM has three states: IDLE, WAIT and ACK.
- **IDLE**, one source per edge, priority prog_we > d_req > i_req:
  - prog_we: write prog_data to istore[prog_addr] and stay in IDLE.
  - d_req or i_req: latch the port select, address, we and wdata; load cnt=LATENCY; go to WAIT.
- **WAIT**:
  - cnt!=0: decrement cnt.
  - cnt==0: perform the access and go to ACK.
    - Read: register the store output into the selected rdata.
    - Write: update dstore.
- **ACK**:
  - Only the selected port's ack is high.
  - Next edge goes to IDLE unconditionally.
  - Requests are not sampled in ACK, which gives the requester one cycle to drop req.
- prog_we outside IDLE is ignored and is not queued. The loader must wait for busy=0.
- The losing requester keeps req high and is served on a later IDLE edge. There is no fairness guarantee; d_req starves i_req by design, because the processor issues at most one data access per instruction.
- Addresses are 4 bits wide and cover the full 16-entry depth, so there is no out-of-range case.
- Store contents:
  - Zero at time 0.
  - Not cleared by reset, so a loaded program survives reset.

## Timing
- Reset values: state IDLE, cnt 0, i_ack 0, d_ack 0, i_rdata 0, d_rdata 0, busy 0.
- Latency: request accepted at edge E0 → ack high in the cycle after edge E0+LATENCY+1. With LATENCY=2, ack is high after E3.
- Back-to-back throughput is one access per LATENCY+3 cycles. The earliest next acceptance is the first IDLE edge after ACK.
- ack is high for exactly one cycle. rdata is registered at the same edge that asserts ack.
- Writes commit at the WAIT→ACK edge. A read of the same address accepted later returns the new value.
- Reset mid-operation, in WAIT or ACK:
  - The access is dropped and no ack is issued.
  - A write in WAIT is not committed.
  - The requester must re-issue.
- Simultaneous prog_we and d_req in IDLE: the program write commits, and d_req is accepted on the next IDLE edge.

## Structure
- Shared package contains:
  - the state encoding (IDLE/WAIT/ACK);
  - the address and data width constants (4, 32, 8);
  - the default LATENCY.
- Sub-module `mem_array`: a parameterized synchronous single-port array (DEPTH, WIDTH) with write enable and a registered read. It is instantiated twice, once for the instruction store and once for the data store.
- The FSM, cnt and arbitration live in mem_responder.

## Test plan
- Preload istore[3]=32'h0083_2020; LATENCY=2; raise i_req with i_addr=3 at E0 → i_ack high only after E3, i_rdata=32'h0083_2020, d_ack stays 0.
- Write d_addr=5, d_wdata=8'hA7, then read d_addr=5 → second d_ack returns d_rdata=8'hA7. d_rdata does not change on the write ack.
- Raise d_req (read addr 2) and i_req (addr 0) in the same IDLE cycle → d_ack first, then i_ack LATENCY+3 cycles later, with correct data for each.
- Raise prog_we (addr 1, 32'hDEAD_BEEF) together with d_req → the program write commits that edge and d_ack follows one cycle later than an unopposed request. A prog_we pulsed while busy=1 leaves istore unchanged.
- Assert reset during WAIT of a write to addr 9 (old value 8'h00) → no d_ack, and busy=0, i_rdata and d_rdata at 0 immediately. A subsequent read of addr 9 returns 8'h00, and the istore contents are intact.
- With LATENCY=0 and i_req held high continuously → i_ack pulses once every 3 cycles, never on consecutive cycles.
